// File: rtl/heartbeat_multi.sv
// Animated seven-segment driver (heartbeat / chase / bounce / blank) for NUM_DIGITS digits.
// Define HEARTBEAT_DP_EN to blink the leftmost decimal point on every animation step.
module heartbeat_multi #(
    parameter int NUM_DIGITS      = 4,
    parameter int PULSE_COUNT_MAX = 50_000_000,
    parameter int DURATION_MAX    = 25
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [1:0]              mode,
    output logic [8*NUM_DIGITS-1:0] dig,
    output logic                    step
);

    localparam int PW   = (PULSE_COUNT_MAX > 1) ? $clog2(PULSE_COUNT_MAX) : 1;
    localparam int DW   = (DURATION_MAX > 1) ? $clog2(DURATION_MAX) : 1;
    localparam int SW   = $clog2(NUM_DIGITS);
    localparam int HALF = NUM_DIGITS / 2;

    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_COUNT_MAX - 1);
    localparam logic [DW-1:0] DUR_LAST   = DW'(DURATION_MAX - 1);

    localparam logic [7:0] LBAR = 8'hCF;
    localparam logic [7:0] RBAR = 8'hF9;
    localparam logic [7:0] DASH = 8'hBF;

    typedef enum logic [1:0] {MODE_HEART, MODE_CHASE, MODE_BOUNCE, MODE_BLANK} mode_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic [PW-1:0]           pulse_cnt;
    logic [DW-1:0]           dur_cnt;
    logic [SW-1:0]           pos;
    logic [SW-1:0]           pos_next;
    logic [SW-1:0]           last_pos;
    dir_t                    dir;
    dir_t                    dir_next;
    mode_t                   mode_q;
    logic                    pulse_wrap;
    logic                    boundary;
    logic [8*NUM_DIGITS-1:0] dig_next;
`ifdef HEARTBEAT_DP_EN
    logic                    parity;
`endif

    always_comb begin
        pulse_wrap = en && (pulse_cnt == PULSE_LAST);
        boundary   = pulse_wrap && (dur_cnt == DUR_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_cnt <= '0;
            dur_cnt   <= '0;
        end else if (en) begin
            pulse_cnt <= pulse_wrap ? '0 : pulse_cnt + 1'b1;
            if (pulse_wrap)
                dur_cnt <= boundary ? '0 : dur_cnt + 1'b1;
        end
    end

    // Heartbeat reuses the bounce walker over half the digits.
    always_comb begin
        pos_next = pos;
        dir_next = dir;
        last_pos = (mode_q == MODE_HEART) ? SW'(HALF - 1) : SW'(NUM_DIGITS - 1);
        if (mode_t'(mode) != mode_q) begin
            pos_next = '0;
            dir_next = DIR_UP;
        end else begin
            case (mode_q)
                MODE_CHASE: pos_next = (pos == last_pos) ? '0 : pos + 1'b1;
                MODE_HEART, MODE_BOUNCE: begin
                    if (last_pos == '0) begin
                        pos_next = '0;
                    end else if (dir == DIR_UP) begin
                        if (pos == last_pos) begin
                            pos_next = pos - 1'b1;
                            dir_next = DIR_DOWN;
                        end else begin
                            pos_next = pos + 1'b1;
                        end
                    end else begin
                        if (pos == '0) begin
                            pos_next = pos + 1'b1;
                            dir_next = DIR_UP;
                        end else begin
                            pos_next = pos - 1'b1;
                        end
                    end
                end
                default: begin
                    pos_next = '0;
                    dir_next = DIR_UP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos    <= '0;
            dir    <= DIR_UP;
            mode_q <= MODE_HEART;
            step   <= 1'b0;
        end else begin
            step <= boundary;
            if (boundary) begin
                mode_q <= mode_t'(mode);
                pos    <= pos_next;
                dir    <= dir_next;
            end
        end
    end

`ifdef HEARTBEAT_DP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            parity <= 1'b0;
        else if (boundary)
            parity <= ~parity;
    end
`endif

    always_comb begin
        dig_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            case (mode_q)
                MODE_HEART: begin
                    if (i == HALF + int'(pos))
                        dig_next[8*i +: 8] = LBAR;
                    else if (i == HALF - 1 - int'(pos))
                        dig_next[8*i +: 8] = RBAR;
                end
                MODE_CHASE, MODE_BOUNCE: begin
                    if (i == int'(pos))
                        dig_next[8*i +: 8] = DASH;
                end
                default: ;
            endcase
        end
`ifdef HEARTBEAT_DP_EN
        dig_next[8*NUM_DIGITS-1] = ~parity;
`endif
    end

    // Segments trail pos by one clock so the decode never sits on the boundary path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            dig <= '1;
        else if (en)
            dig <= dig_next;
    end

endmodule

// File: tb/tb_heartbeat_multi.sv
// Scoreboard bench for heartbeat_multi (4 digits, step every 8 clocks).
// Expected segment patterns follow HEARTBEAT_DP_EN when it is defined.
module tb_heartbeat_multi;

    typedef struct {
        int          gap;
        logic [31:0] dig;
    } exp_t;

`ifdef HEARTBEAT_DP_EN
    localparam bit DP_ON = 1'b1;
`else
    localparam bit DP_ON = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [1:0]  mode;
    logic [31:0] dig;
    logic        step;

    exp_t sb[$];
    exp_t pend;
    logic chk_pending;
    int   since_step;
    int   step_idx;
    int   n_checks;
    int   n_fails;

    heartbeat_multi #(
        .NUM_DIGITS     (4),
        .PULSE_COUNT_MAX(4),
        .DURATION_MAX   (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .mode   (mode),
        .dig    (dig),
        .step   (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] with_dp(logic [31:0] v, int k);
        logic [31:0] r;
        r = v;
        if (DP_ON && (k % 2 == 1))
            r[31] = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] dash_at(int p);
        logic [31:0] r;
        r = '1;
        r[8*p +: 8] = 8'hBF;
        return r;
    endfunction

    function automatic logic [31:0] heart(int phase);
        return (phase == 0) ? 32'hFFCFF9FF : 32'hCFFFFFF9;
    endfunction

    // Queue the pattern expected just after the next step, tagged with its parity index.
    task automatic apply_stimulus(int gap, logic [31:0] raw);
        exp_t e;
        step_idx++;
        e.gap = gap;
        e.dig = with_dp(raw, step_idx);
        sb.push_back(e);
    endtask

    task automatic wait_drain(int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || chk_pending) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0 || chk_pending) begin
            check_output("drain timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    // Monitor: each step pops one expectation; segments are checked a clock later.
    always @(negedge clk) begin
        if (!reset_n) begin
            since_step  = 0;
            chk_pending = 1'b0;
        end else begin
            since_step++;
            if (chk_pending) begin
                check_output("dig after step", dig, pend.dig);
                check_output("step width", 32'(step), 32'd0);
                chk_pending = 1'b0;
            end
            if (step) begin
                if (sb.size() == 0) begin
                    check_output("unexpected step", 32'd1, 32'd0);
                end else begin
                    pend = sb.pop_front();
                    check_output("step gap", 32'(since_step), 32'(pend.gap));
                    chk_pending = 1'b1;
                end
                since_step = 0;
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        step_idx    = 0;
        since_step  = 0;
        chk_pending = 1'b0;
        reset_n     = 1'b0;
        en          = 1'b1;
        mode        = 2'd2;

        repeat (3) @(negedge clk);
        check_output("reset dig", dig, 32'hFFFFFFFF);
        check_output("reset step", 32'(step), 32'd0);
        en   = 1'b0;
        mode = 2'd1;
        @(negedge clk);
        check_output("reset dig en0", dig, 32'hFFFFFFFF);
        check_output("reset step en0", 32'(step), 32'd0);

        mode = 2'd0;
        en   = 1'b1;
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("heartbeat idle", dig, 32'hFFCFF9FF);

        for (int k = 1; k <= 4; k++)
            apply_stimulus(8, heart(k % 2));
        wait_drain(80);

        mode = 2'd1;
        apply_stimulus(8, dash_at(0));
        for (int p = 1; p <= 3; p++)
            apply_stimulus(8, dash_at(p));
        wait_drain(80);

        mode = 2'd2;
        repeat (3) @(negedge clk);
        check_output("mode change mid-step", dig, with_dp(dash_at(3), step_idx));
        begin
            int bounce_pos[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
            foreach (bounce_pos[i])
                apply_stimulus(8, dash_at(bounce_pos[i]));
        end
        wait_drain(120);

        apply_stimulus(28, dash_at(2));
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 10 || c == 20) begin
                check_output("frozen dig", dig, with_dp(dash_at(1), step_idx - 1));
                check_output("frozen step", 32'(step), 32'd0);
            end
        end
        en = 1'b1;
        wait_drain(60);

        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check_output("mid-run reset dig", dig, 32'hFFFFFFFF);
        check_output("mid-run reset step", 32'(step), 32'd0);
        step_idx = 0;
        mode     = 2'd3;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("mode held until step", dig, 32'hFFCFF9FF);
        apply_stimulus(8, 32'hFFFFFFFF);
        apply_stimulus(8, 32'hFFFFFFFF);
        wait_drain(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
